// File: rtl/pad_ow_pkg.sv
// Shared op codes, FSM encodings and default slot timing for the single-wire pad master.
package pad_ow_pkg;

    localparam logic [1:0] OP_RST = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RST_SEQ  = 2'd1;
    localparam logic [1:0] ST_BIT_SLOT = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam int DEF_BIT_CYC    = 16;
    localparam int DEF_LOW_CYC    = 2;
    localparam int DEF_ZERO_CYC   = 12;
    localparam int DEF_SAMPLE_CYC = 6;
    localparam int DEF_RST_CYC    = 64;
    localparam int DEF_PRES_CYC   = 80;
    localparam int DEF_RST_TOTAL  = 128;

endpackage

// File: rtl/pad_sync2.sv
// Two-flop synchronizer for an asynchronous pad input; latency 2 cycles, no backpressure.
// Reset value is a parameter so an idle pulled-up line reads high out of reset.
module pad_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pad_ow_ctrl.sv
// Open-drain single-wire master: reset/write-byte/read-byte over one pull-up pad.
// Byte/reset ops respond 8*BIT_CYC+1 / RST_TOTAL+1 cycles after acceptance; cmd_ready only in IDLE.
module pad_ow_ctrl
    import pad_ow_pkg::*;
#(
    parameter int BIT_CYC    = DEF_BIT_CYC,
    parameter int LOW_CYC    = DEF_LOW_CYC,
    parameter int ZERO_CYC   = DEF_ZERO_CYC,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int RST_CYC    = DEF_RST_CYC,
    parameter int PRES_CYC   = DEF_PRES_CYC,
    parameter int RST_TOTAL  = DEF_RST_TOTAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_presence,
    output logic       busy,
    output logic       pad_din,
    output logic       pad_oen,
    input  logic       pad_dout
);

    localparam int CW = $clog2(RST_TOTAL);
    localparam logic [CW-1:0] C_BIT_END = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] C_LOW     = CW'(LOW_CYC);
    localparam logic [CW-1:0] C_ZERO    = CW'(ZERO_CYC);
    localparam logic [CW-1:0] C_SAMPLE  = CW'(SAMPLE_CYC);
    localparam logic [CW-1:0] C_RST_LOW = CW'(RST_CYC);
    localparam logic [CW-1:0] C_PRES    = CW'(PRES_CYC);
    localparam logic [CW-1:0] C_RST_END = CW'(RST_TOTAL - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    slot_q, slot_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          pres_q, pres_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_pres_q, rsp_pres_d;
    logic          pad_oen_q, pad_oen_d;
    logic [CW-1:0] low_lim;
    logic          line_s;

    pad_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_dout),
        .q     (line_s)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        slot_d     = slot_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        pres_d     = pres_q;
        rsp_data_d = rsp_data_q;
        rsp_pres_d = rsp_pres_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cnt_d  = '0;
                    slot_d = '0;
                    rx_d   = '0;
                    pres_d = 1'b0;
                    // A read is a write of all ones: the device answers by stretching the low.
                    tx_d   = (cmd_op == OP_RD) ? 8'hFF : cmd_data;
                    case (cmd_op)
                        OP_RST: state_d = ST_RST_SEQ;
                        OP_WR:  state_d = ST_BIT_SLOT;
                        OP_RD:  state_d = ST_BIT_SLOT;
                        OP_RSV: begin
                            state_d    = ST_DONE;
                            rsp_data_d = 8'h00;
                            rsp_pres_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_RST_SEQ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_PRES) pres_d = ~line_s;
                if (cnt_q == C_RST_END) begin
                    state_d    = ST_DONE;
                    cnt_d      = '0;
                    rsp_data_d = 8'h00;
                    rsp_pres_d = pres_d;
                end
            end
            ST_BIT_SLOT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_SAMPLE) rx_d = {line_s, rx_q[7:1]};
                if (cnt_q == C_BIT_END) begin
                    cnt_d  = '0;
                    slot_d = slot_q + 3'd1;
                    if (slot_q == 3'd7) begin
                        state_d    = ST_DONE;
                        rsp_data_d = rx_d;
                        rsp_pres_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Decoded from next-state so the registered enable lines up with the slot counter.
        low_lim   = tx_d[slot_d] ? C_LOW : C_ZERO;
        pad_oen_d = 1'b1;
        if (state_d == ST_RST_SEQ)       pad_oen_d = (cnt_d >= C_RST_LOW);
        else if (state_d == ST_BIT_SLOT) pad_oen_d = (cnt_d >= low_lim);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            slot_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            pres_q     <= 1'b0;
            rsp_data_q <= 8'h00;
            rsp_pres_q <= 1'b0;
            pad_oen_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            slot_q     <= slot_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            pres_q     <= pres_d;
            rsp_data_q <= rsp_data_d;
            rsp_pres_q <= rsp_pres_d;
            pad_oen_q  <= pad_oen_d;
        end
    end

    assign cmd_ready    = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign rsp_valid    = (state_q == ST_DONE);
    assign rsp_data     = rsp_data_q;
    assign rsp_presence = rsp_pres_q;
    assign pad_din      = 1'b0;
    assign pad_oen      = pad_oen_q;

endmodule

// File: tb/tb_pad_ow_ctrl.sv
// Directed bench for pad_ow_ctrl with an open-drain line model and a response scoreboard.
module tb_pad_ow_ctrl;
    import pad_ow_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_presence;
    logic       busy;
    logic       pad_din;
    logic       pad_oen;
    logic       pad_dout;
    logic       dev_low;

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp;
    int   n_err;
    int   rsp_cnt;
    int   acc_cyc;
    logic oen_log [0:255];

    // Pull-up line: low if either the master or the bench device pulls it.
    assign pad_dout = pad_oen & ~dev_low;

    pad_ow_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_presence (rsp_presence),
        .busy         (busy),
        .pad_din      (pad_din),
        .pad_oen      (pad_oen),
        .pad_dout     (pad_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Device behaviour per cycle after acceptance: 1 presence pulse, 2 hold slots 1/4, 3 hold slot 0.
    function automatic logic dev_pull(input int mode, input int c);
        int s;
        int k;
        s = (c - 1) / 16;
        k = (c - 1) % 16;
        if (c < 1 || c > 128) return 1'b0;
        case (mode)
            1:       return (c >= 70 && c <= 100);
            2:       return ((s == 1 || s == 4) && k <= 10);
            3:       return (s == 0 && k <= 10);
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic [7:0] d, input logic p, input int cyc);
        exp_t e;
        e.d = d;
        e.p = p;
        e.cyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic sb_pop(input int c);
        exp_t e;
        if (sbq.size() == 0) begin
            check("unexpected_rsp_cycle", 32'(c), 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            check("rsp_cycle", 32'(c), 32'(e.cyc));
            check("rsp_data", 32'(rsp_data), 32'(e.d));
            check("rsp_presence", 32'(rsp_presence), 32'(e.p));
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [7:0] data, input int mode,
                          input bit hold, input int ncyc);
        bit drop;
        check("ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        rsp_cnt   = 0;
        acc_cyc   = -1;
        for (int i = 0; i < 256; i++) oen_log[i] = 1'b1;
        tick();
        if (hold) cmd_op = OP_RSV;
        else cmd_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            dev_low = dev_pull(mode, c);
            #1;
            oen_log[c] = pad_oen;
            if (rsp_valid) begin
                rsp_cnt++;
                sb_pop(c);
            end
            drop = 1'b0;
            if (cmd_valid && cmd_ready && acc_cyc < 0) begin
                acc_cyc = c;
                drop = 1'b1;
            end
            tick();
            if (drop) cmd_valid = 1'b0;
        end
        dev_low = 1'b0;
        check("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int lows;
        n_cmp     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_RST;
        cmd_data  = 8'h00;
        dev_low   = 1'b0;
        #12;
        check("rst_pad_oen", 32'(pad_oen), 32'd1);
        check("rst_pad_din", 32'(pad_din), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'h00);
        check("rst_rsp_presence", 32'(rsp_presence), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Reset op with a device answering presence.
        push(8'h00, 1'b1, 129);
        run_op(OP_RST, 8'h00, 1, 1'b0, 135);
        lows = 0;
        for (int c = 1; c <= 128; c++) if (!oen_log[c]) lows++;
        check("rstseq_low_cycles", 32'(lows), 32'd64);
        check("rstseq_oen_c1", 32'(oen_log[1]), 32'd0);
        check("rstseq_oen_c64", 32'(oen_log[64]), 32'd0);
        check("rstseq_oen_c65", 32'(oen_log[65]), 32'd1);
        check("rstseq_rsp_count", 32'(rsp_cnt), 32'd1);

        // Reset op, nobody on the bus.
        push(8'h00, 1'b0, 129);
        run_op(OP_RST, 8'h00, 0, 1'b0, 135);

        // Write A5: per-slot low width is 2 for a one, 12 for a zero.
        push(8'hA5, 1'b0, 129);
        run_op(OP_WR, 8'hA5, 0, 1'b0, 135);
        for (int s = 0; s < 8; s++) begin
            logic [7:0] wd;
            wd = 8'hA5;
            lows = 0;
            for (int k = 0; k < 16; k++) if (!oen_log[1 + 16 * s + k]) lows++;
            check($sformatf("wr_a5_slot%0d_low", s), 32'(lows), wd[s] ? 32'd2 : 32'd12);
        end
        check("wr_a5_first_low_c1", 32'(oen_log[1]), 32'd0);

        // Read with device pulling slots 1 and 4.
        push(8'hED, 1'b0, 129);
        run_op(OP_RD, 8'h00, 2, 1'b0, 135);

        // Write FF contended in slot 0.
        push(8'hFE, 1'b0, 129);
        run_op(OP_WR, 8'hFF, 3, 1'b0, 135);

        // Held cmd_valid during a read: next (reserved) op accepted right after DONE.
        push(8'hFF, 1'b0, 129);
        push(8'h00, 1'b0, 131);
        run_op(OP_RD, 8'h00, 0, 1'b1, 135);
        check("b2b_accept_cycle", 32'(acc_cyc), 32'd130);
        check("b2b_rsp_count", 32'(rsp_cnt), 32'd2);

        // Reset asserted mid-write while the line is being driven low.
        cmd_valid = 1'b1;
        cmd_op    = OP_WR;
        cmd_data  = 8'h00;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c < 40; c++) tick();
        check("midrst_oen_before", 32'(pad_oen), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_oen_async", 32'(pad_oen), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_rsp_data", 32'(rsp_data), 32'h00);
        check("midrst_rsp_presence", 32'(rsp_presence), 32'd0);
        rsp_cnt = 0;
        for (int c = 0; c < 140; c++) begin
            if (rsp_valid) rsp_cnt++;
            tick();
        end
        check("midrst_no_rsp", 32'(rsp_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pad_ow_ctrl.md
# pad_ow_ctrl

Open-drain single-wire serial master that sequences one pull-up bidirectional pad cell. It drives the pad's `DIN`/`OEN` pins and samples its `DOUT` pin. It accepts reset, write-byte and read-byte commands over a valid/ready handshake and returns the sampled byte and presence flag as a one-cycle response. The line is only ever driven low or released; the pad's pull-up supplies the high level.

## Interface
Parameters:
- `BIT_CYC`, 16, cycles per bit slot
- `LOW_CYC`, 2, low pulse for a '1' bit (also used for read)
- `ZERO_CYC`, 12, low pulse for a '0' bit
- `SAMPLE_CYC`, 6, slot count at which the synchronized line is sampled
- `RST_CYC`, 64, low time of a reset pulse
- `PRES_CYC`, 80, reset count at which presence is sampled
- `RST_TOTAL`, 128, total reset-sequence length

Legal ranges:
- `0 < LOW_CYC < SAMPLE_CYC < ZERO_CYC < BIT_CYC`
- `RST_CYC < PRES_CYC < RST_TOTAL`
- `RST_TOTAL >= BIT_CYC`

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 reset, 01 write byte, 10 read byte, 11 reserved.
- `cmd_data` in 8: write payload.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: sampled byte, LSB first on the wire.
- `rsp_presence` out 1: presence detected (reset op only; 0 otherwise).
- `busy` out 1: high whenever state is not IDLE.
- `pad_din` out 1: constant 0.
- `pad_oen` out 1: 0 drives the line low, 1 releases it.
- `pad_dout` in 1: pad input, asynchronous to `clk`.

## Operation
- States: IDLE, RST_SEQ, BIT_SLOT, DONE.
- Handshake: a command is accepted when `cmd_valid && cmd_ready`. Op and data are registered on acceptance.
- Reserved op 11 is accepted and completes immediately: DONE on the next cycle with `rsp_data` = 0 and `rsp_presence` = 0.
- Counter `cnt` is $clog2(RST_TOTAL) bits wide. It is 0 in the first cycle after acceptance.
- RST_SEQ:
  - `pad_oen` = 0 while `cnt < RST_CYC`, otherwise 1.
  - At `cnt == PRES_CYC`: `presence = ~line_s`.
  - At `cnt == RST_TOTAL-1`: go to DONE.
- BIT_SLOT (8 slots):
  - Write shifts `cmd_data` out LSB first. Read behaves exactly as a write of 8'hFF.
  - Per slot: `pad_oen` = 0 while `cnt < (bit ? LOW_CYC : ZERO_CYC)`.
  - At `cnt == SAMPLE_CYC`: shift `line_s` into the receive register MSB, shifting right.
  - At `cnt == BIT_CYC-1`: `cnt` clears and the slot index increments. After slot 7, go to DONE.
- Write read-back: `rsp_data` returns the bits actually observed on the line. On an uncontended bus this equals `cmd_data`.
- DONE (one cycle):
  - `rsp_valid` = 1 and `cmd_ready` = 0.
  - `rsp_data` and `rsp_presence` update in this cycle and hold until the next DONE.
  - Next state is IDLE.
- `line_s` is the `pad_dout` signal passed through a 2-flop synchronizer whose reset value is 1.

Reset values:
- state IDLE, `pad_oen` 1, `pad_din` 0.
- `cmd_ready` 1, `busy` 0, `rsp_valid` 0.
- `rsp_data` 8'h00, `rsp_presence` 0, `cnt` 0.

## Timing
- Acceptance at cycle 0 → first line-low cycle at cycle 1.
- Byte op: `rsp_valid` at cycle 8·`BIT_CYC`+1, i.e. 129 with defaults. `cmd_ready` returns at cycle 130.
- Reset op: `rsp_valid` at cycle `RST_TOTAL`+1, i.e. 129.
- Reserved op: `rsp_valid` at cycle 1.
- Synchronizer delay: the effective pad sample point is 2 cycles before the sample count (`SAMPLE_CYC`−2 or `PRES_CYC`−2). A line transition within those 2 cycles is metastability-safe but may land on either side of the sample.
- `cmd_valid` while busy has no effect; the command is neither lost nor queued by this block (it simply waits, since `cmd_ready` is 0). A back-to-back command is accepted on the cycle after DONE.
- `rst_n` asserted mid-operation: `pad_oen` goes to 1 immediately (asynchronously) and any partial response is discarded.
- `pad_oen` is registered and glitch-free.

## Structure
- Package `pad_ow_pkg`:
  - op code constants `OP_RST`, `OP_WR`, `OP_RD`
  - state encodings
  - default timing constants
- One sub-module, `pad_sync2`: a 2-flop synchronizer with a reset-value parameter.
- The top module instantiates the pad cell externally; this block exposes only the pad pins.

## Test plan
- Reset op with a bench device that pulls the line low from cycle 70 to 100 → `pad_oen` low for cycles 1–64, `rsp_valid` at 129, `rsp_presence` = 1. Repeat with no device → `rsp_presence` = 0.
- Write 8'hA5 → slot low widths are 2,12,2,12,12,2,12,2 cycles (LSB first); `rsp_data` = 8'hA5; `rsp_valid` at 129.
- Read with the device holding slots 1 and 4 low through the sample point → `rsp_data` = 8'hED.
- Write 8'hFF while the device forces slot 0 low → `rsp_data` = 8'hFE.
- Hold `cmd_valid` during a busy read → second command accepted exactly at cycle 130, with no extra `rsp_valid` pulse.
- Assert `rst_n` low at cycle 40 of a write → `pad_oen` = 1 the same cycle; after release, `cmd_ready` = 1, `rsp_valid` never pulses, and `rsp_data` = 8'h00.
